// File: rtl/lsu_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lsu_mem_arbiter : shares one memory read/write channel among NUM_CONSUMERS LSUs
// Option macro   : LSU_MEM_ARB_ROUND_ROBIN_EN (round-robin scan; else fixed priority)
// Revision       : 1.0
// ============================================================================
module lsu_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_CONSUMERS-1:0]                   consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0]   consumer_read_addr,
    output logic [NUM_CONSUMERS-1:0]                   consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                   consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0]   consumer_write_addr,
    input  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                   consumer_write_ready,
    output logic                                       mem_read_valid,
    output logic [ADDR_WIDTH-1:0]                      mem_read_addr,
    input  logic                                       mem_read_ready,
    input  logic [DATA_WIDTH-1:0]                      mem_read_data,
    output logic                                       mem_write_valid,
    output logic [ADDR_WIDTH-1:0]                      mem_write_addr,
    output logic [DATA_WIDTH-1:0]                      mem_write_data,
    input  logic                                       mem_write_ready
);

    localparam int IDX_W = $clog2(NUM_CONSUMERS);
    localparam logic [IDX_W:0] NUM_C = (IDX_W+1)'(NUM_CONSUMERS);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        READ_WAITING  = 3'd1,
        WRITE_WAITING = 3'd2,
        READ_RELAY    = 3'd3,
        WRITE_RELAY   = 3'd4
    } state_t;

    state_t                                  state, state_nxt;
    logic [IDX_W-1:0]                        gid, gid_nxt;
    logic [IDX_W-1:0]                        scan_base;
    logic                                    found;
    logic [IDX_W-1:0]                        win;
    logic [IDX_W:0]                          cand;

    logic [NUM_CONSUMERS-1:0]                crr_nxt, cwr_nxt;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] crd_nxt;
    logic                                    mrv_nxt, mwv_nxt;
    logic [ADDR_WIDTH-1:0]                   mra_nxt, mwa_nxt;
    logic [DATA_WIDTH-1:0]                   mwd_nxt;

`ifdef LSU_MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W:0]   win_inc;

    assign scan_base = rr_ptr;
    assign win_inc   = {1'b0, win} + (IDX_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (state == IDLE && found) begin
            rr_ptr_nxt = (win_inc >= NUM_C) ? '0 : win_inc[IDX_W-1:0];
        end
    end
`else
    assign scan_base = '0;
`endif

    // First requester at or after scan_base, wrapping modulo NUM_CONSUMERS.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = {1'b0, scan_base} + (IDX_W+1)'(k);
            if (cand >= NUM_C) begin
                cand = cand - NUM_C;
            end
            if (!found && (consumer_read_valid[cand[IDX_W-1:0]] ||
                           consumer_write_valid[cand[IDX_W-1:0]])) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gid_nxt   = gid;
        crr_nxt   = consumer_read_ready;
        cwr_nxt   = consumer_write_ready;
        crd_nxt   = consumer_read_data;
        mrv_nxt   = mem_read_valid;
        mra_nxt   = mem_read_addr;
        mwv_nxt   = mem_write_valid;
        mwa_nxt   = mem_write_addr;
        mwd_nxt   = mem_write_data;
        case (state)
            IDLE: begin
                if (found) begin
                    gid_nxt = win;
                    // Read has precedence when one LSU raises both; the write stays pending.
                    if (consumer_read_valid[win]) begin
                        mrv_nxt   = 1'b1;
                        mra_nxt   = consumer_read_addr[win];
                        state_nxt = READ_WAITING;
                    end else begin
                        mwv_nxt   = 1'b1;
                        mwa_nxt   = consumer_write_addr[win];
                        mwd_nxt   = consumer_write_data[win];
                        state_nxt = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    mrv_nxt      = 1'b0;
                    crd_nxt[gid] = mem_read_data;
                    crr_nxt[gid] = 1'b1;
                    state_nxt    = READ_RELAY;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mwv_nxt      = 1'b0;
                    cwr_nxt[gid] = 1'b1;
                    state_nxt    = WRITE_RELAY;
                end
            end
            READ_RELAY: begin
                if (!consumer_read_valid[gid]) begin
                    crr_nxt[gid] = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            WRITE_RELAY: begin
                if (!consumer_write_valid[gid]) begin
                    cwr_nxt[gid] = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            gid                  <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_addr        <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_addr       <= '0;
            mem_write_data       <= '0;
        end else begin
            state                <= state_nxt;
            gid                  <= gid_nxt;
            consumer_read_ready  <= crr_nxt;
            consumer_write_ready <= cwr_nxt;
            consumer_read_data   <= crd_nxt;
            mem_read_valid       <= mrv_nxt;
            mem_read_addr        <= mra_nxt;
            mem_write_valid      <= mwv_nxt;
            mem_write_addr       <= mwa_nxt;
            mem_write_data       <= mwd_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_lsu_mem_arbiter : directed + randomized bench with a transaction-level model
// Revision           : 1.0
// ============================================================================
module tb_lsu_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
`ifdef LSU_MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]         rv = '0, wv = '0;
    logic [N-1:0][AW-1:0] ra = '0, wa = '0;
    logic [N-1:0][DW-1:0] wd = '0;
    logic                 mrr = 1'b0, mwr = 1'b0;
    logic [DW-1:0]        mrd = '0;

    logic [N-1:0]         crr, cwr;
    logic [N-1:0][DW-1:0] crd;
    logic                 mrv, mwv;
    logic [AW-1:0]        mra, mwa;
    logic [DW-1:0]        mwd;

    lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .consumer_read_valid  (rv),
        .consumer_read_addr   (ra),
        .consumer_read_ready  (crr),
        .consumer_read_data   (crd),
        .consumer_write_valid (wv),
        .consumer_write_addr  (wa),
        .consumer_write_data  (wd),
        .consumer_write_ready (cwr),
        .mem_read_valid       (mrv),
        .mem_read_addr        (mra),
        .mem_read_ready       (mrr),
        .mem_read_data        (mrd),
        .mem_write_valid      (mwv),
        .mem_write_addr       (mwa),
        .mem_write_data       (mwd),
        .mem_write_ready      (mwr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, described by who/kind/phase.
    bit                   m_busy, m_is_wr, m_relay;
    int                   m_who, m_ptr;
    logic                 e_mrv, e_mwv;
    logic [AW-1:0]        e_mra, e_mwa;
    logic [DW-1:0]        e_mwd;
    logic [N-1:0]         e_crr, e_cwr;
    logic [N-1:0][DW-1:0] e_crd;

    task automatic model_reset();
        m_busy = 0; m_is_wr = 0; m_relay = 0; m_who = 0; m_ptr = 0;
        e_mrv = 0; e_mwv = 0; e_mra = '0; e_mwa = '0; e_mwd = '0;
        e_crr = '0; e_cwr = '0; e_crd = '0;
    endtask

    task automatic model_step();
        int start, i;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            start = RR ? m_ptr : 0;
            for (int k = 0; k < N; k++) begin
                i = (start + k) % N;
                if (rv[i] || wv[i]) begin
                    m_busy = 1; m_relay = 0; m_who = i; m_is_wr = !rv[i];
                    m_ptr = (i + 1) % N;
                    if (rv[i]) begin
                        e_mrv = 1; e_mra = ra[i];
                    end else begin
                        e_mwv = 1; e_mwa = wa[i]; e_mwd = wd[i];
                    end
                    break;
                end
            end
        end else if (!m_relay) begin
            if (!m_is_wr && mrr) begin
                e_mrv = 0; e_crd[m_who] = mrd; e_crr[m_who] = 1; m_relay = 1;
            end else if (m_is_wr && mwr) begin
                e_mwv = 0; e_cwr[m_who] = 1; m_relay = 1;
            end
        end else if (!(m_is_wr ? wv[m_who] : rv[m_who])) begin
            e_crr = '0; e_cwr = '0; m_busy = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_mem_read_valid",  64'(mrv), 64'(e_mrv));
            chk("cmp_mem_read_addr",   64'(mra), 64'(e_mra));
            chk("cmp_mem_write_valid", 64'(mwv), 64'(e_mwv));
            chk("cmp_mem_write_addr",  64'(mwa), 64'(e_mwa));
            chk("cmp_mem_write_data",  64'(mwd), 64'(e_mwd));
            chk("cmp_read_ready",      64'(crr), 64'(e_crr));
            chk("cmp_write_ready",     64'(cwr), 64'(e_cwr));
            chk("cmp_read_data",       64'(crd), 64'(e_crd));
        end
    end

    // Behavioural LSUs and memory used when auto_en is set.
    bit          auto_en = 0;
    int unsigned p_new = 0, p_mem = 100, p_stray = 0, p_hold = 0, p_abandon = 0;
    logic [N-1:0] rd_seen = '0, wr_seen = '0;

    task automatic auto_drive();
        for (int i = 0; i < N; i++) begin
            if (rv[i]) begin
                if (crr[i]) begin
                    if (rd_seen[i] && ($urandom % 100) >= p_hold) begin
                        rv[i] = 1'b0; rd_seen[i] = 1'b0;
                    end else rd_seen[i] = 1'b1;
                end else if (($urandom % 1000) < p_abandon) rv[i] = 1'b0;
            end else if (($urandom % 100) < p_new) begin
                rv[i] = 1'b1; ra[i] = AW'($urandom); rd_seen[i] = 1'b0;
            end
            if (wv[i]) begin
                if (cwr[i]) begin
                    if (wr_seen[i] && ($urandom % 100) >= p_hold) begin
                        wv[i] = 1'b0; wr_seen[i] = 1'b0;
                    end else wr_seen[i] = 1'b1;
                end else if (($urandom % 1000) < p_abandon) wv[i] = 1'b0;
            end else if (($urandom % 100) < p_new) begin
                wv[i] = 1'b1; wa[i] = AW'($urandom); wd[i] = DW'($urandom); wr_seen[i] = 1'b0;
            end
        end
        mrr = (mrv && ($urandom % 100) < p_mem) || (($urandom % 100) < p_stray);
        mwr = (mwv && ($urandom % 100) < p_mem) || (($urandom % 100) < p_stray);
        mrd = DW'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        if (auto_en) auto_drive();
    endtask

    int order[$];
    int exp_order[5];
    logic [N-1:0] prev;
    bit rerq, was_low;
    int rt, wt, g0, g3;

    initial begin
        model_reset();
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_mem_read_valid", 64'(mrv), 64'h0);
        chk("reset_read_ready",     64'(crr), 64'h0);
        chk("reset_read_data",      64'(crd), 64'h0);
        rst_n = 1'b1;
        tick();

        // Single read: consumer 2, address 0x3C, memory answers 0xA5 later.
        rv[2] = 1'b1; ra[2] = 8'h3C;
        tick();
        chk("rd_grant_valid", 64'(mrv), 64'h1);
        chk("rd_grant_addr",  64'(mra), 64'h3C);
        tick(); tick();
        mrr = 1'b1; mrd = 8'hA5;
        tick();
        mrr = 1'b0; mrd = 8'h00;
        chk("rd_ready_first",  64'(crr), 64'b0100);
        chk("rd_data",         64'(crd[2]), 64'hA5);
        chk("rd_mem_valid_lo", 64'(mrv), 64'h0);
        tick();
        chk("rd_ready_second", 64'(crr), 64'b0100);
        rv[2] = 1'b0;
        tick();
        chk("rd_ready_end",    64'(crr), 64'h0);
        chk("rd_data_hold",    64'(crd[2]), 64'hA5);

        // Single write: consumer 1 writes 0x7E to 0x10.
        wv[1] = 1'b1; wa[1] = 8'h10; wd[1] = 8'h7E;
        tick();
        chk("wr_grant_valid", 64'(mwv), 64'h1);
        chk("wr_grant_addr",  64'(mwa), 64'h10);
        chk("wr_grant_data",  64'(mwd), 64'h7E);
        tick();
        chk("wr_hold_valid",  64'(mwv), 64'h1);
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        chk("wr_ready_first", 64'(cwr), 64'b0010);
        chk("wr_mem_valid_lo", 64'(mwv), 64'h0);
        tick();
        wv[1] = 1'b0;
        tick();
        chk("wr_ready_end",   64'(cwr), 64'h0);
        tick();
        chk("wr_idle",        64'({mrv, mwv}), 64'h0);

        // Contention: all four read; consumer 0 re-requests while 1 is served.
        auto_en = 1; p_new = 0; p_mem = 100; p_stray = 0; p_hold = 0; p_abandon = 0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1; ra[i] = 8'h40 + AW'(i);
        end
        rd_seen = '0; prev = '0; rerq = 0; order.delete();
`ifdef LSU_MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 0, 2, 3};
`endif
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (crr[i] && !prev[i]) order.push_back(i);
            prev = crr;
            if (!rerq && mrv && mra == 8'h41) begin
                rv[0] = 1'b1; ra[0] = 8'h40; rd_seen[0] = 1'b0; rerq = 1;
            end
        end
        chk("contention_count", 64'(order.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("contention_order%0d", k),
                64'(order.size() > k ? order[k] : 99), 64'(exp_order[k]));
        repeat (10) tick();

        // Same consumer raises read and write together.
        rv[0] = 1'b1; wv[0] = 1'b1; ra[0] = 8'h21; wa[0] = 8'h22; wd[0] = 8'h99;
        rd_seen = '0; wr_seen = '0;
        tick();
        chk("rw_first_is_read", 64'({mrv, mwv}), 64'b10);
        chk("rw_read_addr",     64'(mra), 64'h21);
        rt = -1; wt = -1;
        for (int c = 0; c < 40 && wt < 0; c++) begin
            tick();
            if (crr[0] && rt < 0) rt = c;
            if (cwr[0] && wt < 0) wt = c;
        end
        chk("rw_write_served",      64'(wt >= 0), 64'h1);
        chk("rw_read_before_write", 64'(rt >= 0 && rt < wt), 64'h1);
        repeat (10) tick();

        // Consumers 0 and 3 request continuously.
        rv[0] = 1'b1; rv[3] = 1'b1; ra[0] = 8'h60; ra[3] = 8'h63;
        rd_seen = '0; was_low = 0; g0 = 0; g3 = 0; prev = '0;
        for (int c = 0; c < 48; c++) begin
            tick();
            if (!rv[0] && was_low) begin rv[0] = 1'b1; rd_seen[0] = 1'b0; end
            was_low = !rv[0];
            if (crr[0] && !prev[0]) g0++;
            if (crr[3] && !prev[3]) g3++;
            prev = crr;
        end
`ifdef LSU_MEM_ARB_ROUND_ROBIN_EN
        chk("rr_c3_served", 64'(g3 >= 4), 64'h1);
`else
        chk("fixed_c3_starved", 64'(g3), 64'h0);
        chk("fixed_c0_served",  64'(g0 >= 8), 64'h1);
`endif
        repeat (12) tick();

        // Reset while a read waits on memory; a late memory ready must be ignored.
        auto_en = 0; rv = '0; wv = '0; mrr = 1'b0; mwr = 1'b0;
        tick();
        rv[1] = 1'b1; ra[1] = 8'h5A;
        tick();
        chk("rst_pre_valid", 64'(mrv), 64'h1);
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_mrv",  64'(mrv), 64'h0);
        chk("rst_async_mra",  64'(mra), 64'h0);
        chk("rst_async_crd",  64'(crd), 64'h0);
        rv[1] = 1'b0;
        tick();
        rst_n = 1'b1; mrr = 1'b1; mrd = 8'hEE;
        tick(); tick();
        mrr = 1'b0;
        chk("late_ready_ignored", 64'(crr), 64'h0);
        chk("late_ready_no_mrv",  64'(mrv), 64'h0);

        // Randomized traffic, with one mid-run reset.
        auto_en = 1; p_new = 15; p_mem = 40; p_stray = 5; p_hold = 20; p_abandon = 5;
        rd_seen = '0; wr_seen = '0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c == 2000) begin
                #2 rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
        end
        p_new = 0; p_abandon = 0; p_hold = 0;
        repeat (60) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Shares one external memory channel (one read port, one write port, valid/ready) among NUM_CONSUMERS per-thread LSUs. It accepts LSU read/write requests, grants one at a time, forwards the request to memory, returns the response to the granted LSU, and holds that LSU's ready until the LSU withdraws valid. It sits between the core's LSU array and the data-memory interface.

## Interface
- NUM_CONSUMERS, 4: number of LSU requesters, ≥2
- ADDR_WIDTH, 8: memory address width
- DATA_WIDTH, 8: memory data width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- consumer_read_valid  in  [NUM_CONSUMERS]  per-LSU read request
- consumer_read_addr  in  [NUM_CONSUMERS][ADDR_WIDTH]  per-LSU read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read response valid to LSU
- consumer_read_data  out  [NUM_CONSUMERS][DATA_WIDTH]  read data to LSU
- consumer_write_valid  in  [NUM_CONSUMERS]  per-LSU write request
- consumer_write_addr  in  [NUM_CONSUMERS][ADDR_WIDTH]  per-LSU write address
- consumer_write_data  in  [NUM_CONSUMERS][DATA_WIDTH]  per-LSU write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write-complete to LSU
- mem_read_valid / mem_read_addr  out  1 / ADDR_WIDTH  memory read request
- mem_read_ready / mem_read_data  in  1 / DATA_WIDTH  memory read response
- mem_write_valid / mem_write_addr / mem_write_data  out  1 / ADDR_WIDTH / DATA_WIDTH  memory write request
- mem_write_ready  in  1  memory write completion

## Operation
- States: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAY, WRITE_RELAY. Registers: state, grant index gid, round-robin pointer rr_ptr, and all outputs.
- IDLE: scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS. First index i with consumer_read_valid[i] or consumer_write_valid[i] wins. If both are set for i, read wins and the write stays pending.
- Grant: gid←i; rr_ptr←(i+1) mod NUM_CONSUMERS. Read grant: mem_read_valid←1, mem_read_addr←consumer_read_addr[i], state→READ_WAITING. Write grant: mem_write_valid←1, mem_write_addr/data←consumer_write_addr/data[i], state→WRITE_WAITING.
- READ_WAITING: hold mem_read_valid and address stable. On mem_read_ready: mem_read_valid←0, consumer_read_data[gid]←mem_read_data, consumer_read_ready[gid]←1, state→READ_RELAY.
- WRITE_WAITING: same pattern using mem_write_ready, consumer_write_ready[gid]←1, state→WRITE_RELAY.
- READ_RELAY / WRITE_RELAY: keep ready high while the granted valid stays high. When the granted valid is low: ready←0, state→IDLE. No new grant is issued in the relay cycle.
- consumer_read_data[j] holds its last value until overwritten. Only the granted index is ever written.
- A consumer that drops valid before grant is not serviced. After grant, consumer valid, address and data are ignored until the relay state.

## Timing
- Reset (asynchronous): state=IDLE, rr_ptr=0, gid=0, all valid/ready outputs 0, all addr/data outputs 0. A transaction in flight is abandoned and is not resumed after reset.
- Grant latency: 1 cycle. Request seen in cycle t; mem_*_valid is high from t+1.
- Memory ready seen in cycle m: consumer ready is high from m+1, and mem_*_valid is low from m+1.
- Relay: an LSU that drops valid on the edge where it sees ready (edge ending m+1) sees ready low from m+3. Ready is therefore high for 2 cycles; LSUs must tolerate this.
- Back-to-back: next grant no earlier than the cycle after the relay exit. Minimum 4 cycles per transaction with 0-wait memory.
- mem_read_ready or mem_write_ready arriving outside the matching WAITING state is ignored.

## Configuration
- LSU_MEM_ARB_ROUND_ROBIN_EN defined: round-robin scan starting at rr_ptr, as above.
- Not defined: fixed priority; the scan always starts at index 0 and rr_ptr is not implemented. The lowest index always wins, so starvation is possible by design.

## Test plan
- Single read: consumer 2 reads 0x3C; memory returns 0xA5 after 3 cycles -> mem_read_addr=0x3C; consumer_read_data[2]=0xA5; consumer_read_ready[2] high for 2 cycles; other readies stay 0.
- Single write: consumer 1 writes 0x7E to 0x10 -> mem_write_addr=0x10, mem_write_data=0x7E until mem_write_ready; consumer_write_ready[1] pulses; state returns to IDLE.
- Contention, RR enabled: all 4 consumers request reads at once -> service order 0,1,2,3. A re-request from 0 during service of 1 is served after 3.
- Same-consumer read+write: consumer 0 asserts both -> read is served first, then write on the next grant.
- Reset while in READ_WAITING -> all outputs 0 immediately; a late mem_read_ready after reset produces no consumer ready.
- Macro undefined: consumers 0 and 3 request continuously -> consumer 0 is always granted.
